id_ex_stage: RTL

//  Decode-to-execute pipeline stage; sits directly downstream of the register file.
//  - Captures register-file read data (outA/outB) and decoder control signals into
//    the ID/EX pipeline register.
//  - Bypasses same-cycle write-back data that the register file read path does not

---
 rtl/id_ex_stage_pkg.sv | 45 ++++
 rtl/id_ex_stage_load_use_detect.sv | 35 +++
 rtl/id_ex_stage.sv | 156 +++++++++++++++
 3 files changed

// File: rtl/id_ex_stage_pkg.sv
// id_ex_stage_pkg: shared types and helpers for the ID/EX stage.
//   ctrl_t         decoder control bundle, MSB first:
//                  {reg_write, mem_read, mem_write, mem_to_reg, alu_src,
//                   reg_dst, branch, alu_op[1:0]}
//   instr_fields_t register specifiers and immediate pulled from an instruction
//   REG_ZERO       hard-wired zero register, never bypassed or hazarded on
package id_ex_stage_pkg;

  typedef struct packed {
    logic       reg_write;
    logic       mem_read;
    logic       mem_write;
    logic       mem_to_reg;
    logic       alu_src;
    logic       reg_dst;
    logic       branch;
    logic [1:0] alu_op;
  } ctrl_t;

  localparam int CTRL_W = $bits(ctrl_t);

  localparam logic [4:0] REG_ZERO = 5'd0;

  typedef struct packed {
    logic [4:0]  rs;
    logic [4:0]  rt;
    logic [4:0]  rd;
    logic [15:0] imm;
  } instr_fields_t;

  // Only the low 26 bits carry operand fields; the opcode is not needed here.
  function automatic instr_fields_t decode_fields(logic [25:0] instr);
    instr_fields_t f;
    f.rs  = instr[25:21];
    f.rt  = instr[20:16];
    f.rd  = instr[15:11];
    f.imm = instr[15:0];
    return f;
  endfunction

  function automatic logic [31:0] sext16(logic [15:0] imm);
    return {{16{imm[15]}}, imm};
  endfunction

endpackage

// File: rtl/id_ex_stage_load_use_detect.sv
// load_use_detect: combinational load-use hazard check.
//   id_valid_i            ID holds a real instruction
//   id_alu_src_i,
//   id_mem_write_i,
//   id_branch_i           ID control bits that decide whether rt is a source
//   id_rs_i, id_rt_i      ID source specifiers
//   ex_valid_i            EX holds a real instruction
//   ex_mem_read_i         EX instruction is a load
//   ex_rt_i               EX load destination
//   haz_o                 ID must wait one cycle for the load result
module load_use_detect
  import id_ex_stage_pkg::*;
(
  input  logic       id_valid_i,
  input  logic       id_alu_src_i,
  input  logic       id_mem_write_i,
  input  logic       id_branch_i,
  input  logic [4:0] id_rs_i,
  input  logic [4:0] id_rt_i,
  input  logic       ex_valid_i,
  input  logic       ex_mem_read_i,
  input  logic [4:0] ex_rt_i,
  output logic       haz_o
);

  // rt is a real source for R-type ALU ops, stores (data) and branches (compare);
  // for immediate ALU ops and loads it is a destination and cannot conflict.
  logic uses_rt;
  assign uses_rt = !id_alu_src_i || id_mem_write_i || id_branch_i;

  assign haz_o = id_valid_i && ex_valid_i && ex_mem_read_i &&
                 (ex_rt_i != REG_ZERO) &&
                 ((ex_rt_i == id_rs_i) || (uses_rt && (ex_rt_i == id_rt_i)));

endmodule

// File: rtl/id_ex_stage.sv
// id_ex_stage: ID/EX pipeline register with write-back bypass, load-use
// bubble insertion, branch-flush squash and a saturating stall counter.
//   clk, reset            clock; synchronous active-high reset
//   id_valid, id_instr,
//   id_pc_plus4, id_ctrl  instruction currently in ID
//   rf_out_a, rf_out_b    register file read data for rs / rt
//   wb_reg_write,
//   wb_write_reg,
//   wb_write_data         same-cycle write-back, bypassed onto the operands
//   flush                 squash whatever ID would have delivered
//   stall                 combinational; hold PC and IF/ID this cycle
//   ex_*                  registered EX-side view of the instruction
//   stall_count           saturating count of load-use bubbles
module id_ex_stage
  import id_ex_stage_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int CNT_W  = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              id_valid,
  input  logic [31:0]       id_instr,
  input  logic [31:0]       id_pc_plus4,
  input  logic [DATA_W-1:0] rf_out_a,
  input  logic [DATA_W-1:0] rf_out_b,
  input  logic [CTRL_W-1:0] id_ctrl,
  input  logic              wb_reg_write,
  input  logic [4:0]        wb_write_reg,
  input  logic [DATA_W-1:0] wb_write_data,
  input  logic              flush,
  output logic              stall,
  output logic              ex_valid,
  output logic [CTRL_W-1:0] ex_ctrl,
  output logic [31:0]       ex_pc_plus4,
  output logic [DATA_W-1:0] ex_data_a,
  output logic [DATA_W-1:0] ex_data_b,
  output logic [31:0]       ex_imm,
  output logic [4:0]        ex_rs,
  output logic [4:0]        ex_rt,
  output logic [4:0]        ex_rd,
  output logic [CNT_W-1:0]  stall_count
);

  instr_fields_t f;
  ctrl_t         id_c;
  logic          unused_opcode;

  assign f             = decode_fields(id_instr[25:0]);
  assign id_c          = ctrl_t'(id_ctrl);
  assign unused_opcode = ^id_instr[31:26];

  // ---------------------------------------------------------------- state
  logic              ex_valid_q, ex_valid_d;
  ctrl_t             ex_ctrl_q,  ex_ctrl_d;
  logic [31:0]       ex_pc_q,    ex_pc_d;
  logic [DATA_W-1:0] ex_a_q,     ex_a_d;
  logic [DATA_W-1:0] ex_b_q,     ex_b_d;
  logic [31:0]       ex_imm_q,   ex_imm_d;
  logic [4:0]        ex_rs_q,    ex_rs_d;
  logic [4:0]        ex_rt_q,    ex_rt_d;
  logic [4:0]        ex_rd_q,    ex_rd_d;
  logic [CNT_W-1:0]  cnt_q,      cnt_d;

  // ---------------------------------------------------------------- bypass
  // The register file writes at the clock edge, so its read data this cycle
  // is stale for a register being written back right now.
  logic              byp_a, byp_b;
  logic [DATA_W-1:0] opnd_a, opnd_b;

  assign byp_a  = wb_reg_write && (wb_write_reg != REG_ZERO) && (wb_write_reg == f.rs);
  assign byp_b  = wb_reg_write && (wb_write_reg != REG_ZERO) && (wb_write_reg == f.rt);
  assign opnd_a = byp_a ? wb_write_data : rf_out_a;
  assign opnd_b = byp_b ? wb_write_data : rf_out_b;

  // ---------------------------------------------------------------- hazard
  logic haz;

  load_use_detect u_luse (
    .id_valid_i     (id_valid),
    .id_alu_src_i   (id_c.alu_src),
    .id_mem_write_i (id_c.mem_write),
    .id_branch_i    (id_c.branch),
    .id_rs_i        (f.rs),
    .id_rt_i        (f.rt),
    .ex_valid_i     (ex_valid_q),
    .ex_mem_read_i  (ex_ctrl_q.mem_read),
    .ex_rt_i        (ex_rt_q),
    .haz_o          (haz)
  );

  // A flush already discards ID, so holding it would be pointless.
  assign stall = haz && !flush && !reset;

  // ---------------------------------------------------------------- next state
  always_comb begin
    ex_valid_d = id_valid;
    ex_ctrl_d  = id_valid ? id_c : '0;
    ex_pc_d    = id_pc_plus4;
    ex_a_d     = opnd_a;
    ex_b_d     = opnd_b;
    ex_imm_d   = sext16(f.imm);
    ex_rs_d    = f.rs;
    ex_rt_d    = f.rt;
    ex_rd_d    = f.rd;
    cnt_d      = cnt_q;

    // Bubble: only valid and ctrl matter; the data fields are left to capture
    // whatever ID shows since nothing downstream looks at them.
    if (flush || haz) begin
      ex_valid_d = 1'b0;
      ex_ctrl_d  = '0;
    end

    if (stall && !(&cnt_q))
      cnt_d = cnt_q + CNT_W'(1);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      ex_valid_q <= 1'b0;
      ex_ctrl_q  <= '0;
      ex_pc_q    <= '0;
      ex_a_q     <= '0;
      ex_b_q     <= '0;
      ex_imm_q   <= '0;
      ex_rs_q    <= '0;
      ex_rt_q    <= '0;
      ex_rd_q    <= '0;
      cnt_q      <= '0;
    end else begin
      ex_valid_q <= ex_valid_d;
      ex_ctrl_q  <= ex_ctrl_d;
      ex_pc_q    <= ex_pc_d;
      ex_a_q     <= ex_a_d;
      ex_b_q     <= ex_b_d;
      ex_imm_q   <= ex_imm_d;
      ex_rs_q    <= ex_rs_d;
      ex_rt_q    <= ex_rt_d;
      ex_rd_q    <= ex_rd_d;
      cnt_q      <= cnt_d;
    end
  end

  assign ex_valid    = ex_valid_q;
  assign ex_ctrl     = ex_ctrl_q;
  assign ex_pc_plus4 = ex_pc_q;
  assign ex_data_a   = ex_a_q;
  assign ex_data_b   = ex_b_q;
  assign ex_imm      = ex_imm_q;
  assign ex_rs       = ex_rs_q;
  assign ex_rt       = ex_rt_q;
  assign ex_rd       = ex_rd_q;
  assign stall_count = cnt_q;

endmodule
